// File: rtl/iopad_pwr_seq.sv
// IO pad ring supply sequencer: debounce supply-good, ramp groups on with acks, release isolation; reverse on sleep, safe state on brownout.
// Latency: vdd_good rise -> DEB after 3 edges -> group_en[0] after DEB_CYCLES more; registered outputs. No backpressure; waits on group_ok.
// Optional ack timeout: define IOPAD_PWR_SEQ_TIMEOUT_EN.
module iopad_pwr_seq #(
    parameter int N_GROUPS       = 4,
    parameter int DEB_CYCLES     = 16,
    parameter int STEP_CYCLES    = 8,
`ifdef IOPAD_PWR_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 64,
`endif
    parameter int CW             = 8
) (
    input  logic                ck,
    input  logic                nrst,
    input  logic                vdd_good,
    input  logic [N_GROUPS-1:0] group_ok,
    input  logic                sleep_req,
    input  logic                fault_clr,
    output logic [N_GROUPS-1:0] group_en,
    output logic                iso_n,
    output logic                ready,
    output logic                fault,
    output logic [2:0]          state
);

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_DEB   = 3'd1;
    localparam logic [2:0] S_RAMP  = 3'd2;
    localparam logic [2:0] S_REL   = 3'd3;
    localparam logic [2:0] S_ON    = 3'd4;
    localparam logic [2:0] S_DOWN  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    localparam logic [CW-1:0]       DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]       STEP_LAST = CW'(STEP_CYCLES - 1);
`ifdef IOPAD_PWR_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0]       TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
`endif
    localparam logic [2:0]          IDX_LAST  = 3'(N_GROUPS - 1);
    localparam logic [N_GROUPS-1:0] EN_ONE    = N_GROUPS'(1);

    logic                r_sync1;
    logic                r_vs;
    logic [2:0]          r_state;
    logic [N_GROUPS-1:0] r_en;
    logic                r_iso_n;
    logic                r_ready;
    logic                r_fault;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_idx;
    logic                r_gap;

    logic [N_GROUPS-1:0] w_sel;
    logic [N_GROUPS-1:0] w_sel_next;
    logic                w_ack;
    logic                w_brown;

    // Only the ack of the group currently being ramped is looked at.
    assign w_sel      = EN_ONE << r_idx;
    assign w_sel_next = w_sel << 1;
    assign w_ack      = |(group_ok & w_sel);
    assign w_brown    = !r_vs && ((r_state == S_RAMP) || (r_state == S_REL) ||
                                  (r_state == S_ON)   || (r_state == S_DOWN));

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 1'b0;
            r_vs    <= 1'b0;
            r_state <= S_OFF;
            r_en    <= '0;
            r_iso_n <= 1'b0;
            r_ready <= 1'b0;
            r_fault <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_gap   <= 1'b0;
        end else begin
            r_sync1 <= vdd_good;
            r_vs    <= r_sync1;
            if (w_brown) begin
                r_state <= S_FAULT;
                r_en    <= '0;
                r_iso_n <= 1'b0;
                r_ready <= 1'b0;
                r_fault <= 1'b1;
                r_cnt   <= '0;
                r_gap   <= 1'b0;
            end else begin
                case (r_state)
                    S_OFF: begin
                        if (r_vs && !sleep_req) begin
                            r_state <= S_DEB;
                            r_cnt   <= '0;
                        end
                    end
                    S_DEB: begin
                        if (!r_vs) begin
                            r_state <= S_OFF;
                            r_cnt   <= '0;
                        end else if (r_cnt == DEB_LAST) begin
                            r_state <= S_RAMP;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                            r_gap   <= 1'b0;
                            r_en    <= EN_ONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_RAMP: begin
                        if (r_gap) begin
                            if (r_cnt == STEP_LAST) begin
                                r_cnt <= '0;
                                r_gap <= 1'b0;
                                if (r_idx == IDX_LAST) begin
                                    r_state <= S_REL;
                                end else begin
                                    r_idx <= r_idx + 3'd1;
                                    r_en  <= r_en | w_sel_next;
                                end
                            end else begin
                                r_cnt <= r_cnt + CW'(1);
                            end
                        end else if (w_ack) begin
                            r_gap <= 1'b1;
                            r_cnt <= '0;
                        end
`ifdef IOPAD_PWR_SEQ_TIMEOUT_EN
                        else if (r_cnt == TO_LAST) begin
                            r_state <= S_FAULT;
                            r_en    <= '0;
                            r_iso_n <= 1'b0;
                            r_ready <= 1'b0;
                            r_fault <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
`endif
                    end
                    S_REL: begin
                        r_state <= S_ON;
                        r_iso_n <= 1'b1;
                        r_ready <= 1'b1;
                    end
                    S_ON: begin
                        if (sleep_req) begin
                            r_state <= S_DOWN;
                            r_iso_n <= 1'b0;
                            r_ready <= 1'b0;
                            r_cnt   <= '0;
                            r_idx   <= IDX_LAST;
                        end
                    end
                    S_DOWN: begin
                        // Teardown runs highest group first; the last clear lands back in OFF.
                        if (r_cnt == STEP_LAST) begin
                            r_cnt <= '0;
                            r_en  <= r_en & ~w_sel;
                            if (r_idx == 3'd0) begin
                                r_state <= S_OFF;
                            end else begin
                                r_idx <= r_idx - 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_FAULT: begin
                        if (fault_clr && !r_vs) begin
                            r_state <= S_OFF;
                            r_fault <= 1'b0;
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_OFF;
                        r_en    <= '0;
                        r_iso_n <= 1'b0;
                        r_ready <= 1'b0;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign group_en = r_en;
    assign iso_n    = r_iso_n;
    assign ready    = r_ready;
    assign fault    = r_fault;
    assign state    = r_state;

endmodule

// File: tb/tb_iopad_pwr_seq.sv
// Directed bench for iopad_pwr_seq: ramp, debounce glitch, sleep teardown, brownout/fault clear, stuck ack, async reset.
module tb_iopad_pwr_seq;

    logic       ck;
    logic       nrst;
    logic       vdd_good;
    logic [3:0] group_ok;
    logic       sleep_req;
    logic       fault_clr;
    logic [3:0] group_en;
    logic       iso_n;
    logic       ready;
    logic       fault;
    logic [2:0] state;

    int         total;
    int         bad;
    int         cyc;
    logic [3:0] en_prev;
    logic [3:0] ok_mask;

    iopad_pwr_seq dut (
        .ck        (ck),
        .nrst      (nrst),
        .vdd_good  (vdd_good),
        .group_ok  (group_ok),
        .sleep_req (sleep_req),
        .fault_clr (fault_clr),
        .group_en  (group_en),
        .iso_n     (iso_n),
        .ready     (ready),
        .fault     (fault),
        .state     (state)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock; group_ok models a one-cycle-late ack register on group_en.
    task automatic tick();
        @(posedge ck);
        #1;
        cyc++;
        group_ok = en_prev & ok_mask;
        en_prev  = group_en;
    endtask

    task automatic tick_to(input int e);
        while (cyc < e) tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        en_prev   = 4'h0;
        ok_mask   = 4'hF;
        nrst      = 1'b0;
        vdd_good  = 1'b0;
        group_ok  = 4'h0;
        sleep_req = 1'b0;
        fault_clr = 1'b0;

        repeat (3) @(posedge ck);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_en", 32'(group_en), 32'h0);
        chk("rst_iso", 32'(iso_n), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        // Power-up ramp: edge 1 is the first edge after vdd_good rises.
        nrst     = 1'b1;
        vdd_good = 1'b1;
        tick_to(2);   chk("up_off_e2", 32'(state), 32'd0);
        tick_to(3);   chk("up_deb_e3", 32'(state), 32'd1);
        tick_to(18);  chk("up_en_e18", 32'(group_en), 32'h0);
        tick_to(19);  chk("up_en_e19", 32'(group_en), 32'h1);
                      chk("up_ramp_e19", 32'(state), 32'd2);
        tick_to(28);  chk("up_en_e28", 32'(group_en), 32'h1);
        tick_to(29);  chk("up_en_e29", 32'(group_en), 32'h3);
        tick_to(39);  chk("up_en_e39", 32'(group_en), 32'h7);
        tick_to(49);  chk("up_en_e49", 32'(group_en), 32'hF);
        tick_to(59);  chk("up_rel_e59", 32'(state), 32'd3);
                      chk("up_iso_e59", 32'(iso_n), 32'd0);
        tick_to(60);  chk("up_on_e60", 32'(state), 32'd4);
                      chk("up_iso_e60", 32'(iso_n), 32'd1);
                      chk("up_ready_e60", 32'(ready), 32'd1);

        // Sleep teardown.
        sleep_req = 1'b1;
        tick_to(61);  chk("dn_state_e61", 32'(state), 32'd5);
                      chk("dn_iso_e61", 32'(iso_n), 32'd0);
                      chk("dn_ready_e61", 32'(ready), 32'd0);
                      chk("dn_en_e61", 32'(group_en), 32'hF);
        tick_to(68);  chk("dn_en_e68", 32'(group_en), 32'hF);
        tick_to(69);  chk("dn_en_e69", 32'(group_en), 32'h7);
        tick_to(77);  chk("dn_en_e77", 32'(group_en), 32'h3);
        tick_to(85);  chk("dn_en_e85", 32'(group_en), 32'h1);
        tick_to(92);  chk("dn_state_e92", 32'(state), 32'd5);
        tick_to(93);  chk("dn_en_e93", 32'(group_en), 32'h0);
                      chk("dn_off_e93", 32'(state), 32'd0);
        tick_to(95);  chk("dn_hold_off", 32'(state), 32'd0);

        // Debounce interrupted at cnt=10, then a fresh full debounce.
        sleep_req = 1'b0;
        tick_to(96);  chk("deb_enter", 32'(state), 32'd1);
        tick_to(106);
        vdd_good = 1'b0;
        tick_to(108); chk("deb_still", 32'(state), 32'd1);
        tick_to(109); chk("deb_abort", 32'(state), 32'd0);
                      chk("deb_abort_en", 32'(group_en), 32'h0);
        vdd_good = 1'b1;
        tick_to(111); chk("deb_wait_sync", 32'(state), 32'd0);
        tick_to(112); chk("deb_reenter", 32'(state), 32'd1);
        tick_to(127); chk("deb_en_e127", 32'(group_en), 32'h0);
        tick_to(128); chk("deb_en_e128", 32'(group_en), 32'h1);
        tick_to(168); chk("deb_rel", 32'(state), 32'd3);
        tick_to(169); chk("deb_on", 32'(state), 32'd4);
                      chk("deb_on_en", 32'(group_en), 32'hF);

        // Brownout in ON and fault clear qualification.
        tick_to(170);
        vdd_good = 1'b0;
        tick_to(172); chk("bo_still_on", 32'(state), 32'd4);
        tick_to(173); chk("bo_state", 32'(state), 32'd6);
                      chk("bo_fault", 32'(fault), 32'd1);
                      chk("bo_en", 32'(group_en), 32'h0);
                      chk("bo_iso", 32'(iso_n), 32'd0);
                      chk("bo_ready", 32'(ready), 32'd0);
        vdd_good = 1'b1;
        tick_to(175);
        fault_clr = 1'b1;
        tick_to(176);
        fault_clr = 1'b0;
                      chk("clr_ign_state", 32'(state), 32'd6);
                      chk("clr_ign_fault", 32'(fault), 32'd1);
        vdd_good = 1'b0;
        tick_to(178);
        fault_clr = 1'b1;
        tick_to(179);
        fault_clr = 1'b0;
                      chk("clr_state", 32'(state), 32'd0);
                      chk("clr_fault", 32'(fault), 32'd0);

        // Group 2 never acks.
        ok_mask  = 4'b1011;
        vdd_good = 1'b1;
        tick_to(182); chk("stk_deb", 32'(state), 32'd1);
        tick_to(198); chk("stk_en1", 32'(group_en), 32'h1);
        tick_to(218); chk("stk_en7", 32'(group_en), 32'h7);
`ifdef IOPAD_PWR_SEQ_TIMEOUT_EN
        tick_to(281); chk("to_wait", 32'(state), 32'd2);
        tick_to(282); chk("to_state", 32'(state), 32'd6);
                      chk("to_fault", 32'(fault), 32'd1);
                      chk("to_en", 32'(group_en), 32'h0);
`else
        tick_to(400); chk("stk_state", 32'(state), 32'd2);
                      chk("stk_en_hold", 32'(group_en), 32'h7);

        // Asynchronous reset mid-RAMP, checked between clock edges.
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_en", 32'(group_en), 32'h0);
        chk("arst_iso", 32'(iso_n), 32'd0);
        chk("arst_fault", 32'(fault), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
